axil_mem_bridge: RTL and testbench

- Parametrised successor to the CPU-to-memory AXI-lite path; one block holds a CPU-side request/response port, an internal AXI-lite master FSM, an internal AXI-lite slave FSM and a simple memory port.
- Adds byte strobes, a configurable memory read latency, an explicit response handshake with error status, and optional address-range checking.
- Sits between the core's load/store unit and data memory; one transaction in flight at a time.

---
 rtl/axil_mem_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_axil_mem_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_bridge.sv
// CPU request port -> internal AXI-lite master/slave pair -> simple memory port, one transaction in flight.
// Define AXIL_ADDR_CHECK_EN to return SLVERR for accesses that run past MEM_SIZE.
module axil_mem_bridge #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] MEM_SIZE = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  mem_ren,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {M_IDLE, M_WR, M_WRESP, M_RD, M_RDATA, M_DONE} m_state_t;
  typedef enum logic [1:0] {S_IDLE, S_BRESP, S_RWAIT, S_RRESP} s_state_t;

  m_state_t r_m_state, w_m_next;
  s_state_t r_s_state, w_s_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic              w_awvalid, w_awready, w_wvalid, w_wready, w_bvalid, w_bready;
  logic              w_arvalid, w_arready, w_rvalid, w_rready;
  logic [ADDR_W-1:0] w_awaddr;
  logic [1:0]        w_bresp, w_rresp;
  logic [DATA_W-1:0] w_rdata;

  logic [1:0]        r_s_resp;
  logic [DATA_W-1:0] r_s_rdata;
  logic [2:0]        r_cnt;
  logic              r_rd_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [STRB_W-1:0] r_mem_wstrb;
  logic              r_mem_wen, r_mem_ren;
  logic              w_addr_err;

  // The AW and AR channels share the latched request address.
  assign w_awaddr = r_addr;

`ifdef AXIL_ADDR_CHECK_EN
  localparam int AXW = ADDR_W + 1;
  logic [ADDR_W:0] w_end_addr;
  assign w_end_addr = {1'b0, w_awaddr} + AXW'(STRB_W);
  assign w_addr_err = w_end_addr > AXW'(MEM_SIZE);
`else
  assign w_addr_err = 1'b0;
`endif

  always_comb begin
    w_m_next   = r_m_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_awvalid  = 1'b0;
    w_wvalid   = 1'b0;
    w_bready   = 1'b0;
    w_arvalid  = 1'b0;
    w_rready   = 1'b0;
    case (r_m_state)
      M_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_m_next = req_we ? M_WR : M_RD;
      end
      M_WR: begin
        w_awvalid = 1'b1;
        w_wvalid  = 1'b1;
        if (w_awready && w_wready) w_m_next = M_WRESP;
      end
      M_WRESP: begin
        w_bready = 1'b1;
        if (w_bvalid) w_m_next = M_DONE;
      end
      M_RD: begin
        w_arvalid = 1'b1;
        if (w_arready) w_m_next = M_RDATA;
      end
      M_RDATA: begin
        w_rready = 1'b1;
        if (w_rvalid) w_m_next = M_DONE;
      end
      M_DONE: begin
        resp_valid = 1'b1;
        w_m_next   = M_IDLE;
      end
      default: w_m_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m_state    <= M_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_m_state <= w_m_next;
      if (req_valid && req_ready) begin
        r_addr       <= req_addr;
        r_wdata      <= req_wdata;
        r_wstrb      <= req_wstrb;
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b0;
      end
      if (w_bvalid && w_bready) r_resp_err <= w_bresp[1];
      if (w_rvalid && w_rready) begin
        r_resp_rdata <= w_rdata;
        r_resp_err   <= w_rresp[1];
      end
    end
  end

  always_comb begin
    w_s_next  = r_s_state;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_arready = 1'b0;
    w_bvalid  = 1'b0;
    w_rvalid  = 1'b0;
    case (r_s_state)
      S_IDLE: begin
        if (w_awvalid && w_wvalid) begin
          w_awready = 1'b1;
          w_wready  = 1'b1;
          w_s_next  = S_BRESP;
        end else if (w_arvalid) begin
          w_arready = 1'b1;
          w_s_next  = S_RWAIT;
        end
      end
      S_BRESP: begin
        w_bvalid = 1'b1;
        if (w_bready) w_s_next = S_IDLE;
      end
      S_RWAIT: if (r_cnt == 3'd0) w_s_next = S_RRESP;
      S_RRESP: begin
        w_rvalid = 1'b1;
        if (w_rready) w_s_next = S_IDLE;
      end
      default: w_s_next = S_IDLE;
    endcase
  end

  assign w_bresp = r_s_resp;
  assign w_rresp = r_s_resp;
  assign w_rdata = r_s_rdata;

  // Errored reads sit one cycle in S_RWAIT with the counter at zero and no mem_ren.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s_state   <= S_IDLE;
      r_s_resp    <= 2'b00;
      r_s_rdata   <= '0;
      r_cnt       <= 3'd0;
      r_rd_err    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_ren   <= 1'b0;
    end else begin
      r_s_state <= w_s_next;
      r_mem_wen <= 1'b0;
      r_mem_ren <= 1'b0;
      if (w_awvalid && w_awready) begin
        r_mem_addr  <= w_awaddr;
        r_mem_wdata <= r_wdata;
        r_mem_wstrb <= r_wstrb;
        r_mem_wen   <= (r_wstrb != '0) && !w_addr_err;
        r_s_resp    <= w_addr_err ? 2'b10 : 2'b00;
      end
      if (w_arvalid && w_arready) begin
        r_mem_addr <= w_awaddr;
        r_mem_ren  <= !w_addr_err;
        r_rd_err   <= w_addr_err;
        r_cnt      <= w_addr_err ? 3'd0 : 3'(MEM_LAT);
      end
      if (r_s_state == S_RWAIT) begin
        if (r_cnt == 3'd0) begin
          r_s_rdata <= r_rd_err ? '0 : mem_rdata;
          r_s_resp  <= r_rd_err ? 2'b10 : 2'b00;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
    end
  end

  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_wen    = r_mem_wen;
  assign mem_ren    = r_mem_ren;

endmodule

// File: tb/tb_axil_mem_bridge.sv
// Bench for axil_mem_bridge: two instances (MEM_LAT 1 and 3) against a word-array reference memory.
module tb_axil_mem_bridge;
`ifdef AXIL_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] MSIZE = 32'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, req_valid, req_ready, req_we, resp_valid, resp_err, mem_wen, mem_ren;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0]  req_wstrb, mem_wstrb;

  int checks = 0;
  int errors = 0;

  logic [31:0] phys_mem [2][128];
  logic [31:0] ref_mem  [2][128];
  int          rem      [2];
  logic [31:0] ren_addr [2];

  axil_mem_bridge #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MEM_SIZE(MSIZE)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .mem_addr(mem_addr[0]), .mem_wen(mem_wen[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
    .mem_ren(mem_ren[0]), .mem_rdata(mem_rdata[0]));

  axil_mem_bridge #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MEM_SIZE(MSIZE)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .mem_addr(mem_addr[1]), .mem_wen(mem_wen[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
    .mem_ren(mem_ren[1]), .mem_rdata(mem_rdata[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Memory device: rdata is valid only in the cycle exactly MEM_LAT after mem_ren, garbage otherwise.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mem_wen[g])
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[g][b]) phys_mem[g][mem_addr[g][8:2]][8*b +: 8] = mem_wdata[g][8*b +: 8];
      if (mem_ren[g]) begin
        rem[g] = lat_of(g);
        ren_addr[g] = mem_addr[g];
      end else if (rem[g] >= 0) begin
        rem[g] = rem[g] - 1;
      end
      mem_rdata[g] = (rem[g] == 0) ? phys_mem[g][ren_addr[g][8:2]] : $urandom;
    end
  end

  // Must be called at a negedge; returns at the negedge of the cycle after resp_valid.
  task automatic do_txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input string tag);
    bit          err_exp;
    int          n, exp_resp;
    int          wen_cnt, ren_cnt, wen_cyc, ren_cyc, resp_cyc;
    bit          busy_ready;
    logic [31:0] wen_addr, wen_data, rdata, exp_rdata;
    logic [3:0]  wen_strb;
    logic        rerr;
    err_exp = CHK && ((addr + 32'd4) > MSIZE);
    wen_cnt = 0; ren_cnt = 0; wen_cyc = -1; ren_cyc = -1; resp_cyc = -1; busy_ready = 1'b0;
    wen_addr = '0; wen_data = '0; wen_strb = '0; rdata = '0; rerr = 1'b0;
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_at_start got %b want 1", tag, req_ready[d]);
    end
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_wstrb[d] = strb;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (we && !err_exp)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[d][addr[8:2]][8*b +: 8] = wdata[8*b +: 8];
    exp_rdata = (!we && !err_exp) ? ref_mem[d][addr[8:2]] : 32'h0;
    for (int c = 1; c <= 40 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid[d] = 1'b0; req_we[d] = $urandom; req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_wstrb[d] = $urandom;
      end
      if (mem_wen[d]) begin
        wen_cnt++;
        if (wen_cyc < 0) begin
          wen_cyc = c; wen_addr = mem_addr[d]; wen_data = mem_wdata[d]; wen_strb = mem_wstrb[d];
        end
      end
      if (mem_ren[d]) begin
        ren_cnt++;
        if (ren_cyc < 0) ren_cyc = c;
      end
      if (req_ready[d]) busy_ready = 1'b1;
      if (resp_valid[d]) begin
        resp_cyc = c; rdata = resp_rdata[d]; rerr = resp_err[d];
      end
    end
    @(negedge clk);
    checks++;
    if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || mem_wen[d] !== 1'b0 || mem_ren[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s after_resp got valid=%b ready=%b wen=%b ren=%b want 0 1 0 0",
               tag, resp_valid[d], req_ready[d], mem_wen[d], mem_ren[d]);
    end
    exp_resp = we ? 3 : (err_exp ? 4 : 4 + lat_of(d));
    checks++;
    if (resp_cyc !== exp_resp) begin
      errors++;
      $display("FAIL %s resp_cycle got %0d want %0d", tag, resp_cyc, exp_resp);
    end
    checks++;
    if (rerr !== err_exp || rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s resp_data got err=%b rdata=%h want err=%b rdata=%h", tag, rerr, rdata, err_exp, exp_rdata);
    end
    checks++;
    if (busy_ready) begin
      errors++;
      $display("FAIL %s busy_ready got 1 want 0", tag);
    end
    if (we) begin
      checks++;
      if (wen_cnt !== ((strb != 4'h0 && !err_exp) ? 1 : 0) || ren_cnt !== 0) begin
        errors++;
        $display("FAIL %s wr_pulses got wen=%0d ren=%0d want wen=%0d ren=0", tag, wen_cnt, ren_cnt,
                 (strb != 4'h0 && !err_exp) ? 1 : 0);
      end
      if (strb != 4'h0 && !err_exp) begin
        checks++;
        if (wen_cyc !== 2 || wen_addr !== addr || wen_data !== wdata || wen_strb !== strb) begin
          errors++;
          $display("FAIL %s mem_write got cyc=%0d addr=%h data=%h strb=%h want 2 %h %h %h",
                   tag, wen_cyc, wen_addr, wen_data, wen_strb, addr, wdata, strb);
        end
      end
    end else begin
      checks++;
      if (ren_cnt !== (err_exp ? 0 : 1) || wen_cnt !== 0 || (!err_exp && ren_cyc !== 2)) begin
        errors++;
        $display("FAIL %s rd_pulses got ren=%0d at %0d wen=%0d want ren=%0d at 2 wen=0",
                 tag, ren_cnt, ren_cyc, wen_cnt, err_exp ? 0 : 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 2'b00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || {resp_valid[d], resp_err[d], mem_wen[d], mem_ren[d]} !== 4'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d] got ready=%b flags=%b want 1 0000", d, req_ready[d],
                 {resp_valid[d], resp_err[d], mem_wen[d], mem_ren[d]});
      end
      checks++;
      if ({resp_rdata[d], mem_addr[d], mem_wdata[d], mem_wstrb[d]} !== '0) begin
        errors++;
        $display("FAIL reset_data[%0d] got rdata=%h addr=%h wdata=%h strb=%h want 0", d,
                 resp_rdata[d], mem_addr[d], mem_wdata[d], mem_wstrb[d]);
      end
    end
    rst = 2'b11;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_lat1");
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd_lat1");
    do_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_lat3");
    do_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, "rd_lat3");
  endtask

  task automatic test_strobe();
    do_txn(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, "strb_init");
    do_txn(0, 1'b1, 32'h20, 32'h01020304, 4'h0, "strb_zero");
    do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'b0101, "strb_0101");
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, "strb_readback");
  endtask

  task automatic test_addr_check();
    do_txn(0, 1'b0, 32'h100, 32'h0, 4'h0, "rd_0x100");
    do_txn(0, 1'b1, 32'h104, 32'h55AA55AA, 4'hF, "wr_0x104");
    do_txn(0, 1'b1, 32'hFC, 32'h12345678, 4'hF, "wr_0xfc");
    do_txn(1, 1'b0, 32'hFC, 32'h0, 4'h0, "rd_0xfc_lat3");
    do_txn(1, 1'b0, 32'h1F0, 32'h0, 4'h0, "rd_0x1f0_lat3");
  endtask

  task automatic test_random();
    int          d;
    bit          we;
    logic [31:0] a, w;
    logic [3:0]  s;
    for (int i = 0; i < 60; i++) begin
      d  = $urandom_range(0, 1);
      we = $urandom_range(0, 1);
      a  = 32'($urandom_range(0, 79)) << 2;
      w  = $urandom;
      s  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      do_txn(d, we, a, w, s, "random");
    end
  endtask

  task automatic test_reset_mid_read();
    int ren_late, resp_seen;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10; req_wstrb[1] = 4'h0;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ren[1] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ren got %b want 1", mem_ren[1]);
    end
    rst[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[1] !== 1'b1 || mem_addr[1] !== 32'h0 || resp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state got ready=%b addr=%h valid=%b want 1 0 0", req_ready[1], mem_addr[1],
               resp_valid[1]);
    end
    rst[1] = 1'b1;
    ren_late = 0; resp_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_ren[1]) ren_late++;
      if (resp_valid[1]) resp_seen++;
    end
    checks++;
    if (ren_late !== 0 || resp_seen !== 0) begin
      errors++;
      $display("FAIL rstmid_drop got ren=%0d resp=%0d want 0 0", ren_late, resp_seen);
    end
    do_txn(1, 1'b1, 32'h30, 32'hA5A5_0F0F, 4'hF, "rstmid_next_wr");
    do_txn(1, 1'b0, 32'h30, 32'h0, 4'h0, "rstmid_next_rd");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      rem[g] = -1;
      ren_addr[g] = '0;
      mem_rdata[g] = '0;
      for (int i = 0; i < 128; i++) begin
        phys_mem[g][i] = '0;
        ref_mem[g][i] = '0;
      end
    end
    rst = 2'b00; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    test_reset();
    test_directed();
    test_strobe();
    test_addr_check();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
